// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit: funct3 codes, FSM states
// and the ALU opcodes the decoder selects for branch comparisons.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [3:0] ALU_OP_SUB_SIGNED  = 4'b0110;
    localparam logic [3:0] ALU_OP_BR_UNSIGNED = 4'b0111;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        REDIRECT = 2'b01,
        FLUSH    = 2'b10
    } br_state_t;

    // Unsigned branches (funct3[1] set) use the unsigned compare opcode.
    function automatic logic [3:0] branch_alu_op(input logic [2:0] f3);
        logic [3:0] op;
        if (f3[1]) begin
            op = ALU_OP_BR_UNSIGNED;
        end else begin
            op = ALU_OP_SUB_SIGNED;
        end
        return op;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation: funct3 + ALU flags -> taken/illegal.
module branch_cond_eval (
    input  logic [2:0] funct3,
    input  logic       con_blt,
    input  logic       zero,
    output logic       taken,
    output logic       illegal
);
    import branch_pkg::*;

    // Decode branch type into outcome; unknown funct3 is never taken
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:           taken = zero;
            F3_BNE:           taken = ~zero;
            F3_BLT, F3_BLTU:  taken = con_blt;
            F3_BGE, F3_BGEU:  taken = ~con_blt;
            default:          illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_flag_checker.sv
// Checker for ALU flag consistency seen by the branch resolve unit.
module branch_flag_checker (
    input logic clk,
    input logic reset,
    input logic in_valid,
    input logic con_blt,
    input logic con_bgt,
    input logic zero
);

    // Less-than, greater-than and equal are mutually exclusive outcomes
    flags_onehot0_a: assert property (@(posedge clk) disable iff (reset)
        in_valid |-> $onehot0({con_blt, con_bgt, zero}));

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve stage: checks the fetch prediction, redirects and flushes on a mispredict.
// Optional branch statistics counters enabled by defining BRANCH_STATS_EN.
module branch_resolve_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic            con_blt,
    input  logic            con_bgt,
    input  logic            zero,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            pred_taken,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            illegal,
    output logic            misalign,
    output logic [31:0]     stat_total,
    output logic [31:0]     stat_mispred
);
    import branch_pkg::*;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    br_state_t       state_r;
    br_state_t       next_state_s;
    logic [3:0]      flush_cnt_r;
    logic            accept_s;
    logic            taken_s;
    logic            illegal_s;
    logic            misalign_s;
    logic            mispred_s;
    logic [XLEN-1:0] target_s;
    logic            redirect_valid_r;
    logic [XLEN-1:0] redirect_pc_r;
    logic            flush_r;
    logic            illegal_r;
    logic            misalign_r;

    assign in_ready = (state_r == IDLE);
    assign accept_s = in_valid & in_ready;

    branch_cond_eval u_cond_eval (
        .funct3  (funct3),
        .con_blt (con_blt),
        .zero    (zero),
        .taken   (taken_s),
        .illegal (illegal_s)
    );

    branch_flag_checker u_flag_checker (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .con_blt  (con_blt),
        .con_bgt  (con_bgt),
        .zero     (zero)
    );

    // Next-PC selection; both sums wrap silently at XLEN bits
    always_comb begin
        target_s = pc + XLEN'(32'd4);
        if (taken_s) begin
            target_s = pc + imm;
        end else begin
            target_s = pc + XLEN'(32'd4);
        end
    end

    // Illegal branches are never taken, so misalign implies a legal taken branch
    assign misalign_s = taken_s & target_s[1];
    assign mispred_s  = (taken_s != pred_taken) & ~illegal_s & ~misalign_s;

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && mispred_s) begin
                    next_state_s = REDIRECT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            REDIRECT: begin
                if (FLUSH_CYCLES == 32'sd1) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt_r <= 4'd1) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = FLUSH;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Flush counter: loaded on redirect, counts down the remaining flush cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt_r <= 4'd0;
        end else if (state_r == REDIRECT) begin
            flush_cnt_r <= FLUSH_LOAD;
        end else if ((state_r == FLUSH) && (flush_cnt_r != 4'd0)) begin
            flush_cnt_r <= flush_cnt_r - 4'd1;
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

    // Registered outputs; redirect_pc only updates on a real redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= '0;
            flush_r          <= 1'b0;
            illegal_r        <= 1'b0;
            misalign_r       <= 1'b0;
        end else begin
            redirect_valid_r <= accept_s & mispred_s;
            flush_r          <= (next_state_s != IDLE);
            illegal_r        <= accept_s & illegal_s;
            misalign_r       <= accept_s & misalign_s;
            if (accept_s && mispred_s) begin
                redirect_pc_r <= target_s;
            end else begin
                redirect_pc_r <= redirect_pc_r;
            end
        end
    end

    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;
    assign flush          = flush_r;
    assign illegal        = illegal_r;
    assign misalign       = misalign_r;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_total_r;
    logic [31:0] stat_mispred_r;

    // Saturating counters; misaligned branches count as total but not mispredicts
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_total_r   <= 32'd0;
            stat_mispred_r <= 32'd0;
        end else begin
            if (accept_s && !illegal_s && (stat_total_r != 32'hFFFF_FFFF)) begin
                stat_total_r <= stat_total_r + 32'd1;
            end else begin
                stat_total_r <= stat_total_r;
            end
            if (accept_s && mispred_s && (stat_mispred_r != 32'hFFFF_FFFF)) begin
                stat_mispred_r <= stat_mispred_r + 32'd1;
            end else begin
                stat_mispred_r <= stat_mispred_r;
            end
        end
    end

    assign stat_total   = stat_total_r;
    assign stat_mispred = stat_mispred_r;
`else
    assign stat_total   = 32'd0;
    assign stat_mispred = 32'd0;
`endif

endmodule
